sliding_window_sched: RTL and testbench
=======================================

Name: sliding_window_sched

Overview:
Stream-side controller that sequences the 2-D sliding-window line buffer for one frame at a time. It accepts a raster pixel stream with a valid/ready handshake and drives the window's shift enable and window reset. It tracks the row and column position and flags a valid output only when the KxK window lies fully inside the image. Output backpressure stalls the window shift and the input stream; the block sits between the pixel source and the convolution datapath.

Parameters:
KERNEL_SIZE, 3, window edge K; legal range 2..ROW_WIDTH
ROW_WIDTH, 800, image width W in pixels
COL_HEIGHT, 600, image height H in rows
WORD_SIZE, 8, pixel width in bits (signed)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high; all state cleared on the posedge where it is high
in_valid  input  1  source presents a pixel
in_ready  output  1  block accepts the pixel (combinational)
in_pixel  input  WORD_SIZE  raster-order pixel, signed
in_sof  input  1  qualifies in_pixel as pixel (0,0) of a frame
win_shift  output  1  shift enable to window; equals in_valid & in_ready
win_pixel  output  WORD_SIZE  pixel to window; wired from in_pixel
win_reset  output  1  one-cycle clear of window contents and internal counter
out_valid  output  1  window contents form a complete in-image KxK neighbourhood
out_ready  input  1  consumer takes the window
out_row  output  clog2(H)  image row of the window's bottom-right pixel
out_col  output  clog2(W)  image column of the window's bottom-right pixel
frame_done  output  1  one-cycle pulse after the last window of a frame is consumed
sof_err  output  1  sticky flag: in_sof seen mid-frame; cleared only by reset

Behaviour:
- Reset values: state=IDLE, row=col=0, in_ready=1, out_valid=0, out_row=out_col=0, win_reset=0, frame_done=0, sof_err=0.
- States: IDLE, STREAM, DRAIN, ABORT.
- IDLE: in_ready=1. A handshake with in_sof=0 drops the pixel: no shift, no count. A handshake with in_sof=1 shifts it in as (0,0), sets col=1, row=0, and moves to STREAM. If W=1, col wraps to 0 and row becomes 1.
- STREAM: in_ready = !in_sof & (!out_valid | out_ready).
- Each handshake in STREAM shifts the window and advances col. At col=W-1, col wraps to 0 and row increments.
- A handshake on the pixel at (r,c) with r>=K-1 and c>=K-1 sets out_valid on the next cycle, with out_row=r and out_col=c.
- out_valid holds, with stable out_row and out_col, until out_valid & out_ready. A pixel accepted in the same cycle as a pop may set out_valid again: back-to-back with no bubble.
- The handshake on pixel (H-1,W-1) moves the block to DRAIN.
- DRAIN: in_ready=0. Once out_valid=0, or on the cycle out_valid & out_ready, assert frame_done and win_reset for one cycle, then return to IDLE.
- in_sof=1 with in_valid=1 in STREAM: the pixel is not accepted. Go to ABORT and set sof_err.
- ABORT: out_valid is forced to 0 (the pending window is discarded), win_reset pulses, row=col=0, then return to IDLE. In IDLE the still-presented sof pixel is accepted.
- Window latency: window contents reflect a pixel one cycle after its shift, aligned with out_valid.
- win_reset and win_shift are never high in the same cycle.
- Windows per frame: (H-K+1)*(W-K+1).
- Reset mid-frame: all state returns to reset values at the next edge. The window is cleared by the system reset, not by win_reset.

Optional Feature:
SLIDING_WINDOW_SCHED_PERF_EN
- Defined: adds outputs perf_frames (16-bit; increments on frame_done, wraps) and perf_stalls (32-bit, saturating). perf_stalls counts cycles in STREAM with in_valid=1 and in_ready=0. Both counters clear on reset.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- K=3, W=5, H=4, pixels 1..20 with sof on 1, in_valid and out_ready always high:
  - exactly 6 out_valid cycles, at (r,c) = (2,2),(2,3),(2,4),(3,2),(3,3),(3,4);
  - the first window's bottom row is 11,12,13;
  - frame_done pulses once.
- Same frame, out_ready low for 3 cycles at the first window: out_valid and out_row/out_col stay stable, in_ready=0, win_shift=0, no pixel lost; total windows still 6.
- Pixels 7,8 with in_sof=0 while in IDLE, then the frame: 7 and 8 are dropped (win_shift=0); the frame result matches scenario 1.
- in_sof asserted on the 9th pixel of a frame: sof_err=1, one win_reset pulse, out_valid=0; the restarted frame yields 6 windows; sof_err stays 1.
- Assert reset at the 12th pixel: next cycle state=IDLE and all outputs at reset values; a subsequent full frame produces 6 windows.
- Two frames back-to-back with the second sof presented during DRAIN: the sof pixel waits (in_ready=0) until IDLE, then is accepted; 12 windows and 2 frame_done pulses total.

Source files
------------

// File: rtl/sliding_window_sched.sv
// rtl/sliding_window_sched.sv - raster-stream sequencer for a KxK sliding-window line buffer
// Optional perf counters (perf_frames, perf_stalls): define SLIDING_WINDOW_SCHED_PERF_EN
module sliding_window_sched #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_WIDTH   = 800,
  parameter int COL_HEIGHT  = 600,
  parameter int WORD_SIZE   = 8,
  localparam int ROW_BITS   = (COL_HEIGHT > 1) ? $clog2(COL_HEIGHT) : 1,
  localparam int COL_BITS   = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WORD_SIZE-1:0] in_pixel,
  input  logic                        in_sof,
  output logic                        win_shift,
  output logic signed [WORD_SIZE-1:0] win_pixel,
  output logic                        win_reset,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_BITS-1:0]         out_row,
  output logic [COL_BITS-1:0]         out_col,
  output logic                        frame_done,
  output logic                        sof_err
`ifdef SLIDING_WINDOW_SCHED_PERF_EN
  ,
  output logic [15:0]                 perf_frames,
  output logic [31:0]                 perf_stalls
`endif
);

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(COL_HEIGHT - 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(ROW_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] K_ROW    = ROW_BITS'(KERNEL_SIZE - 1);
  localparam logic [COL_BITS-1:0] K_COL    = COL_BITS'(KERNEL_SIZE - 1);
  // A kernel taller than the image never yields a window.
  localparam logic                HAS_WIN  = (KERNEL_SIZE <= COL_HEIGHT);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, ABORT} state_t;

  state_t              state, state_next;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic                at_last, in_window, pop, sof_clash;

  assign win_pixel = in_pixel;
  assign at_last   = (row == LAST_ROW) && (col == LAST_COL);
  assign in_window = HAS_WIN && (row >= K_ROW) && (col >= K_COL);
  assign pop       = out_valid & out_ready;
  assign sof_clash = (state == STREAM) & in_valid & in_sof;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    win_shift  = 1'b0;
    win_reset  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready  = 1'b1;
        win_shift = in_valid & in_sof;
        if (win_shift) state_next = at_last ? DRAIN : STREAM;
      end
      STREAM: begin
        in_ready  = ~in_sof & (~out_valid | out_ready);
        win_shift = in_valid & in_ready;
        if (sof_clash)                 state_next = ABORT;
        else if (win_shift && at_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (~out_valid | out_ready) begin
          frame_done = 1'b1;
          win_reset  = 1'b1;
          state_next = IDLE;
        end
      end
      ABORT: begin
        win_reset  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      sof_err   <= 1'b0;
    end else begin
      state <= state_next;
      // Counters are zero in IDLE, so the sof pixel lands at (0,0) through the normal advance.
      if (win_reset) begin
        row <= '0;
        col <= '0;
      end else if (win_shift) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (sof_clash) begin
        out_valid <= 1'b0;
      end else if (win_shift && in_window) begin
        out_valid <= 1'b1;
        out_row   <= row;
        out_col   <= col;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      if (sof_clash) sof_err <= 1'b1;
    end
  end

`ifdef SLIDING_WINDOW_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_frames <= '0;
      perf_stalls <= '0;
    end else begin
      if (frame_done) perf_frames <= perf_frames + 1'b1;
      if ((state == STREAM) && in_valid && !in_ready && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sliding_window_sched.sv
// tb/tb_sliding_window_sched.sv - self-checking bench for sliding_window_sched (K=3, W=5, H=4)
module tb_sliding_window_sched;
  localparam int K = 3;
  localparam int W = 5;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int PH_WAIT  = 0;
  localparam int PH_IN    = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_ABORT = 3;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_sof, out_ready;
  logic [7:0] in_pixel, win_pixel;
  logic       in_ready, win_shift, win_reset, out_valid, frame_done, sof_err;
  logic [1:0] out_row;
  logic [2:0] out_col;

  int   checks = 0;
  int   errors = 0;
  int   m_phase = PH_WAIT;
  int   m_acc = 0;
  int   m_r = 0;
  int   m_c = 0;
  int   windows = 0;
  int   frames = 0;
  logic m_valid = 1'b0;
  logic m_err = 1'b0;
  int   wlog[$];
  int   shlog[$];

  sliding_window_sched #(
    .KERNEL_SIZE(K), .ROW_WIDTH(W), .COL_HEIGHT(H), .WORD_SIZE(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .win_shift(win_shift), .win_pixel(win_pixel), .win_reset(win_reset),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; in_pixel = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_win_shift",  32'(win_shift),  32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_row",    32'(out_row),    32'd0);
    chk("rst_out_col",    32'(out_col),    32'd0);
    chk("rst_win_reset",  32'(win_reset),  32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sof_err",    32'(sof_err),    32'd0);
    m_phase = PH_WAIT; m_valid = 1'b0; m_err = 1'b0; m_acc = 0;
  endtask

  // One clock: drive inputs, compare every output with the protocol model, advance the model.
  task automatic tick(input logic v, input logic [7:0] pix, input logic sof, input logic ordy,
                      output logic sh);
    logic e_rdy, e_shift, e_wr, e_fd, nv;
    int   pos;
    @(negedge clk);
    in_valid = v; in_pixel = pix; in_sof = sof; out_ready = ordy;
    #2;
    e_rdy = 1'b0; e_shift = 1'b0; e_wr = 1'b0; e_fd = 1'b0;
    case (m_phase)
      PH_WAIT:  begin e_rdy = 1'b1; e_shift = v & sof; end
      PH_IN:    begin e_rdy = ~sof & (~m_valid | ordy); e_shift = v & e_rdy; end
      PH_DRAIN: begin e_fd = ~m_valid | ordy; e_wr = e_fd; end
      default:  e_wr = 1'b1;
    endcase
    chk("in_ready",   32'(in_ready),   32'(e_rdy));
    chk("win_shift",  32'(win_shift),  32'(e_shift));
    chk("win_reset",  32'(win_reset),  32'(e_wr));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("out_valid",  32'(out_valid),  32'(m_valid));
    chk("sof_err",    32'(sof_err),    32'(m_err));
    if (m_valid) begin
      chk("out_row", 32'(out_row), 32'(m_r));
      chk("out_col", 32'(out_col), 32'(m_c));
    end
    if (e_shift) chk("win_pixel", 32'(win_pixel), 32'(pix));

    if (m_valid & ordy) begin
      windows++;
      wlog.push_back(m_r * W + m_c);
    end
    nv = m_valid & ~ordy;
    if (e_shift) shlog.push_back(int'(pix));
    case (m_phase)
      PH_WAIT: if (e_shift) begin m_acc = 1; m_phase = PH_IN; end
      PH_IN: begin
        if (v & sof) begin
          m_phase = PH_ABORT; m_err = 1'b1; nv = 1'b0;
        end else if (e_shift) begin
          pos = m_acc;
          if (pos / W >= K - 1 && pos % W >= K - 1) begin
            nv = 1'b1; m_r = pos / W; m_c = pos % W;
          end
          m_acc++;
          if (m_acc == N) m_phase = PH_DRAIN;
        end
      end
      PH_DRAIN: if (e_fd) begin m_phase = PH_WAIT; frames++; end
      default: m_phase = PH_WAIT;
    endcase
    m_valid = nv;
    sh = e_shift;
  endtask

  // Feeds nframes frames; sof_at restarts the frame with an sof mid-frame, rst_at resets there.
  task automatic drive(input int nframes, input int gap_pct, input int stall_pct, input int sof_at,
                       input int rst_at, input bit stall_first, input int ofs);
    int   idx = 0, fed = 0, cyc = 0, held = 0;
    int   f0 = frames, w0 = windows;
    bit   restarted = 0, rst_done = 0;
    logic v, sof, ordy, sh;
    while (frames - f0 < nframes) begin
      if (cyc > 3000) begin
        chk("timeout", 32'd0, 32'd1);
        break;
      end
      cyc++;
      if (rst_at >= 0 && !rst_done && idx == rst_at) begin
        do_reset();
        rst_done = 1; idx = 0;
        continue;
      end
      sof  = (idx == 0) || (idx == sof_at && !restarted);
      v    = (fed < nframes) && ($urandom_range(99) >= gap_pct);
      ordy = ($urandom_range(99) >= stall_pct);
      if (stall_first && m_valid && windows == w0 && held < 3) begin
        ordy = 1'b0; held++;
      end
      tick(v, 8'(ofs + idx + 1), sof, ordy, sh);
      if (sh) begin
        if (sof && idx != 0) begin restarted = 1; idx = 1; end
        else idx++;
        if (idx == N) begin idx = 0; fed++; end
      end
    end
  endtask

  task automatic check_frame_log(input string tag);
    int i = 0;
    chk({tag, "_windows"}, 32'(windows), 32'd6);
    chk({tag, "_frames"},  32'(frames),  32'd1);
    for (int r = K - 1; r < H; r++)
      for (int c = K - 1; c < W; c++) begin
        chk({tag, "_pos"}, 32'((i < wlog.size()) ? wlog[i] : -1), 32'(r * W + c));
        i++;
      end
  endtask

  task automatic clear_logs();
    windows = 0; frames = 0;
    wlog.delete(); shlog.delete();
  endtask

  initial begin
    logic sh;
    int   ofs;
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; in_pixel = 8'd0;
    do_reset();

    clear_logs();
    drive(1, 0, 0, -1, -1, 0, 0);
    check_frame_log("basic");
    chk("bottom_row0", 32'((shlog.size() > 12) ? shlog[10] : -1), 32'd11);
    chk("bottom_row1", 32'((shlog.size() > 12) ? shlog[11] : -1), 32'd12);
    chk("bottom_row2", 32'((shlog.size() > 12) ? shlog[12] : -1), 32'd13);

    clear_logs();
    drive(1, 0, 0, -1, -1, 1, 0);
    check_frame_log("stall");
    chk("stall_shifts", 32'(shlog.size()), 32'(N));

    clear_logs();
    tick(1'b1, 8'd7, 1'b0, 1'b1, sh);
    tick(1'b1, 8'd8, 1'b0, 1'b1, sh);
    drive(1, 0, 0, -1, -1, 0, 0);
    check_frame_log("drop");
    chk("drop_first_pixel", 32'((shlog.size() > 0) ? shlog[0] : -1), 32'd1);

    clear_logs();
    drive(1, 0, 0, 8, -1, 0, 0);
    check_frame_log("abort");
    chk("abort_sticky", 32'(sof_err), 32'd1);

    clear_logs();
    drive(1, 0, 0, -1, 11, 0, 0);
    check_frame_log("midreset");

    clear_logs();
    drive(2, 0, 0, -1, -1, 0, 0);
    chk("b2b_windows", 32'(windows), 32'd12);
    chk("b2b_frames",  32'(frames),  32'd2);

    for (int f = 0; f < 4; f++) begin
      clear_logs();
      ofs = int'($urandom_range(200));
      drive(1, int'($urandom_range(40)), int'($urandom_range(50)), -1, -1, 0, ofs);
      chk("rand_windows", 32'(windows), 32'd6);
    end
    for (int f = 0; f < 2; f++) begin
      clear_logs();
      drive(1, int'($urandom_range(30)), int'($urandom_range(30)),
            int'($urandom_range(N - 1, 1)), -1, 0, int'($urandom_range(200)));
      chk("rand_abort_frames", 32'(frames), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
